uart_cmd_parser: RTL and testbench

Receive-side command interpreter for the UART link. It consumes the byte stream popped from the UART RX FIFO (one byte per rx_done pulse) and parses ASCII command lines. From those lines it produces binary control strobes and a packed time value for the watch and stopwatch blocks. It is the inverse of the ASCII status sender: that block turns binary into text, this block turns text into binary.

---
 rtl/uart_cmd_parser.sv | 274 +++++++++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser
//
// Receive-side command interpreter for the UART link. Consumes bytes popped
// from the UART RX FIFO and turns ASCII command lines into binary strobes
// and a packed time value for the watch and stopwatch blocks.
//
// Accepted lines (CR-terminated, uppercase, case-sensitive):
//   Thh:mm:ss:cc  -> o_time_data loaded, o_time_valid pulse
//   R             -> o_sw_run pulse
//   P             -> o_sw_stop pulse
//   C             -> o_sw_clear pulse
// Anything malformed, out of range or stalled too long pulses o_err.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   rx_data      received byte, valid while rx_done=1
//   rx_done      1-cycle strobe per received byte
//   o_time_data  packed {hour[23:19], min[18:13], sec[12:7], csec[6:0]}
//   o_time_valid 1-cycle pulse, o_time_data updated this cycle
//   o_sw_run     1-cycle pulse, stopwatch run
//   o_sw_stop    1-cycle pulse, stopwatch stop
//   o_sw_clear   1-cycle pulse, stopwatch clear
//   o_err        1-cycle pulse, line rejected or timed out
//   o_busy       high while a line is partially received
// ---------------------------------------------------------------------------
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [23:0] o_time_data,
  output logic        o_time_valid,
  output logic        o_sw_run,
  output logic        o_sw_stop,
  output logic        o_sw_clear,
  output logic        o_err,
  output logic        o_busy
);

  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_P     = 8'h50;
  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_COLON = 8'h3A;

  // The idle timer only ever has to count up to TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHORT,
    TIME,
    WAIT_CR,
    DISCARD
  } parserState_t;

  parserState_t r_state;
  parserState_t w_nextState;

  logic [3:0]    r_pos;
  logic [7:0]    r_cmd;
  logic [6:0]    r_hour;
  logic [6:0]    r_min;
  logic [6:0]    r_sec;
  logic [6:0]    r_csec;
  logic [23:0]   r_timeData;
  logic [TW-1:0] r_timer;

  logic r_timeValid;
  logic r_swRun;
  logic r_swStop;
  logic r_swClear;
  logic r_err;

  logic       w_isCr;
  logic       w_isDigit;
  logic       w_colonPos;
  logic       w_posOk;
  logic       w_rangeOk;
  logic       w_timeout;
  logic [6:0] w_digit;
  logic [6:0] w_tens;

  logic w_timeValidNext;
  logic w_swRunNext;
  logic w_swStopNext;
  logic w_swClearNext;
  logic w_errNext;

  // Byte classification shared by the next-state and datapath logic.
  // Positions 2, 5 and 8 of the time field are the colon separators;
  // every other position must carry a decimal digit.
  assign w_isCr     = (rx_data == CH_CR);
  assign w_isDigit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign w_colonPos = (r_pos == 4'd2) || (r_pos == 4'd5) || (r_pos == 4'd8);
  assign w_posOk    = w_colonPos ? (rx_data == CH_COLON) : w_isDigit;
  assign w_digit    = {3'b000, rx_data[3:0]};
  assign w_tens     = w_digit * 7'd10;
  assign w_rangeOk  = (r_hour < 7'd24) && (r_min < 7'd60) && (r_sec < 7'd60);

  // The timer fires only when no byte arrives on the expiry cycle, so an
  // incoming byte always wins the race and is parsed normally.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state != IDLE) &&
                     !rx_done && (r_timer == TMAX);

  // State register. Reset drops any partial line straight back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Bytes only move the FSM while rx_done is high; a
  // timeout is the one transition that happens without a byte.
  always_comb begin
    w_nextState = r_state;
    if (rx_done) begin
      unique case (r_state)
        IDLE: begin
          if (rx_data == CH_T) begin
            w_nextState = TIME;
          end else if ((rx_data == CH_R) || (rx_data == CH_P) || (rx_data == CH_C)) begin
            w_nextState = SHORT;
          end else if ((rx_data == CH_LF) || (rx_data == CH_SP) || w_isCr) begin
            w_nextState = IDLE;
          end else begin
            w_nextState = DISCARD;
          end
        end
        SHORT: begin
          w_nextState = w_isCr ? IDLE : DISCARD;
        end
        TIME: begin
          if (!w_posOk) begin
            w_nextState = DISCARD;
          end else if (r_pos == 4'd10) begin
            w_nextState = WAIT_CR;
          end else begin
            w_nextState = TIME;
          end
        end
        WAIT_CR: begin
          w_nextState = w_isCr ? IDLE : DISCARD;
        end
        DISCARD: begin
          if (w_isCr) begin
            w_nextState = IDLE;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end else if (w_timeout) begin
      w_nextState = IDLE;
    end
  end

  // Output decode. Every pulse is decided on the cycle that carries the
  // terminating CR (or on the timeout cycle) and is registered below, so a
  // line produces at most one pulse, one cycle later.
  always_comb begin
    w_timeValidNext = 1'b0;
    w_swRunNext     = 1'b0;
    w_swStopNext    = 1'b0;
    w_swClearNext   = 1'b0;
    w_errNext       = w_timeout;
    if (rx_done && w_isCr) begin
      unique case (r_state)
        SHORT: begin
          w_swRunNext   = (r_cmd == CH_R);
          w_swStopNext  = (r_cmd == CH_P);
          w_swClearNext = (r_cmd == CH_C);
        end
        WAIT_CR: begin
          w_timeValidNext = w_rangeOk;
          w_errNext       = !w_rangeOk;
        end
        DISCARD: begin
          w_errNext = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Field accumulators. A tens digit overwrites its field with d*10 and the
  // following units digit adds d, so each field never exceeds 99.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos  <= 4'd0;
      r_cmd  <= 8'h00;
      r_hour <= 7'd0;
      r_min  <= 7'd0;
      r_sec  <= 7'd0;
      r_csec <= 7'd0;
    end else if (rx_done) begin
      if (r_state == IDLE) begin
        if (rx_data == CH_T) begin
          r_pos  <= 4'd0;
          r_hour <= 7'd0;
          r_min  <= 7'd0;
          r_sec  <= 7'd0;
          r_csec <= 7'd0;
        end
        if ((rx_data == CH_R) || (rx_data == CH_P) || (rx_data == CH_C)) begin
          r_cmd <= rx_data;
        end
      end else if ((r_state == TIME) && w_posOk) begin
        r_pos <= r_pos + 4'd1;
        case (r_pos)
          4'd0:    r_hour <= w_tens;
          4'd1:    r_hour <= r_hour + w_digit;
          4'd3:    r_min  <= w_tens;
          4'd4:    r_min  <= r_min + w_digit;
          4'd6:    r_sec  <= w_tens;
          4'd7:    r_sec  <= r_sec + w_digit;
          4'd9:    r_csec <= w_tens;
          4'd10:   r_csec <= r_csec + w_digit;
          default: ;
        endcase
      end
    end
  end

  // Inter-byte idle timer. It restarts on every byte, sits at zero in IDLE
  // and also clears on the cycle it fires.
  always_ff @(posedge clk) begin
    if (rst || rx_done || (r_state == IDLE) || w_timeout || (TIMEOUT_CYCLES == 0)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // Registered pulses and the packed time value. The time register only
  // changes on a fully validated line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeData  <= 24'h0;
      r_timeValid <= 1'b0;
      r_swRun     <= 1'b0;
      r_swStop    <= 1'b0;
      r_swClear   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_timeValid <= w_timeValidNext;
      r_swRun     <= w_swRunNext;
      r_swStop    <= w_swStopNext;
      r_swClear   <= w_swClearNext;
      r_err       <= w_errNext;
      if (w_timeValidNext) begin
        r_timeData <= {r_hour[4:0], r_min[5:0], r_sec[5:0], r_csec};
      end
    end
  end

  assign o_time_data  = r_timeData;
  assign o_time_valid = r_timeValid;
  assign o_sw_run     = r_swRun;
  assign o_sw_stop    = r_swStop;
  assign o_sw_clear   = r_swClear;
  assign o_err        = r_err;
  assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_parser
//
// Directed bench for uart_cmd_parser with TIMEOUT_CYCLES=1000. Bytes are
// driven on the falling edge so the parser samples them on the next rising
// edge; outputs are read on falling edges.
// ---------------------------------------------------------------------------
module tb_uart_cmd_parser;

  localparam int unsigned TMO = 1000;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [23:0] o_time_data;
  logic        o_time_valid;
  logic        o_sw_run;
  logic        o_sw_stop;
  logic        o_sw_clear;
  logic        o_err;
  logic        o_busy;

  int testCount;
  int failCount;

  int errCnt;
  int validCnt;
  int runCnt;
  int stopCnt;
  int clearCnt;

  int baseErr;
  int baseValid;
  int baseRun;
  int baseStop;
  int baseClear;

  uart_cmd_parser #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .o_time_data (o_time_data),
    .o_time_valid(o_time_valid),
    .o_sw_run    (o_sw_run),
    .o_sw_stop   (o_sw_stop),
    .o_sw_clear  (o_sw_clear),
    .o_err       (o_err),
    .o_busy      (o_busy)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse monitor: counts every cycle each strobe is high, so a pulse that
  // lasts two cycles shows up as two.
  always @(posedge clk) begin
    if (!rst) begin
      errCnt   += int'(o_err);
      validCnt += int'(o_time_valid);
      runCnt   += int'(o_sw_run);
      stopCnt  += int'(o_sw_stop);
      clearCnt += int'(o_sw_clear);
    end
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One byte, one rx_done cycle; consecutive calls give back-to-back bytes.
  task automatic sendByte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  // Sends a string, optionally followed by CR, with no gaps between bytes.
  task automatic applyStimulus(input string s, input bit withCr);
    for (int i = 0; i < s.len(); i++) begin
      sendByte(s[i]);
    end
    if (withCr) begin
      sendByte(8'h0D);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
    end
  endtask

  task automatic snapCounts();
    baseErr   = errCnt;
    baseValid = validCnt;
    baseRun   = runCnt;
    baseStop  = stopCnt;
    baseClear = clearCnt;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    errCnt    = 0;
    validCnt  = 0;
    runCnt    = 0;
    stopCnt   = 0;
    clearCnt  = 0;
    rst       = 1'b1;
    rx_data   = 8'h00;
    rx_done   = 1'b0;

    // Reset state.
    idle(3);
    checkOutput("reset_data",  32'(o_time_data), 32'h0);
    checkOutput("reset_pulses", {27'd0, o_time_valid, o_sw_run, o_sw_stop, o_sw_clear, o_err}, 32'h0);
    checkOutput("reset_busy",  32'(o_busy), 32'h0);
    rst = 1'b0;
    idle(2);

    // Valid time line 12:34:56:78.
    snapCounts();
    applyStimulus("T12:34:56:78", 1'b1);
    checkOutput("time_valid_pulse", 32'(o_time_valid), 32'h1);
    checkOutput("time_data", 32'(o_time_data), 32'h645C4E);
    idle(1);
    checkOutput("time_valid_drop", 32'(o_time_valid), 32'h0);
    idle(3);
    checkOutput("time_valid_count", 32'(validCnt - baseValid), 32'd1);
    checkOutput("time_err_count", 32'(errCnt - baseErr), 32'd0);

    // Out-of-range hour, then out-of-range minute.
    snapCounts();
    applyStimulus("T24:00:00:00", 1'b1);
    checkOutput("hour24_err", 32'(o_err), 32'h1);
    checkOutput("hour24_data", 32'(o_time_data), 32'h645C4E);
    applyStimulus("T09:60:00:00", 1'b1);
    checkOutput("min60_err", 32'(o_err), 32'h1);
    idle(3);
    checkOutput("range_err_count", 32'(errCnt - baseErr), 32'd2);
    checkOutput("range_valid_count", 32'(validCnt - baseValid), 32'd0);
    checkOutput("range_data_kept", 32'(o_time_data), 32'h645C4E);

    // Back-to-back short commands followed by an ignored LF.
    snapCounts();
    applyStimulus("R", 1'b1);
    checkOutput("run_pulse", {29'd0, o_sw_run, o_sw_stop, o_sw_clear}, 32'b100);
    applyStimulus("P", 1'b1);
    checkOutput("stop_pulse", {29'd0, o_sw_run, o_sw_stop, o_sw_clear}, 32'b010);
    applyStimulus("C", 1'b1);
    checkOutput("clear_pulse", {29'd0, o_sw_run, o_sw_stop, o_sw_clear}, 32'b001);
    sendByte(8'h0A);
    checkOutput("lf_busy", 32'(o_busy), 32'h0);
    idle(3);
    checkOutput("short_counts", {8'(runCnt - baseRun), 8'(stopCnt - baseStop),
                                 8'(clearCnt - baseClear), 8'(errCnt - baseErr)}, 32'h01010100);

    // Malformed lines: bad separator, unknown letter, doubled letter.
    snapCounts();
    applyStimulus("T12-34:56:78", 1'b1);
    applyStimulus("x", 1'b1);
    applyStimulus("RR", 1'b1);
    idle(3);
    checkOutput("malformed_err_count", 32'(errCnt - baseErr), 32'd3);
    checkOutput("malformed_other", 32'((validCnt - baseValid) + (runCnt - baseRun) +
                                       (stopCnt - baseStop) + (clearCnt - baseClear)), 32'd0);
    applyStimulus("C", 1'b1);
    checkOutput("after_malformed_clear", 32'(o_sw_clear), 32'h1);
    idle(3);

    // Timeout: last byte sampled at edge E0, error visible after edge E1000.
    snapCounts();
    applyStimulus("T12:3", 1'b0);
    idle(TMO - 1);
    checkOutput("tmo_before_err", 32'(o_err), 32'h0);
    checkOutput("tmo_before_busy", 32'(o_busy), 32'h1);
    idle(1);
    checkOutput("tmo_err", 32'(o_err), 32'h1);
    checkOutput("tmo_busy", 32'(o_busy), 32'h0);
    idle(3);
    checkOutput("tmo_err_count", 32'(errCnt - baseErr), 32'd1);

    // Byte arriving exactly on the expiry cycle keeps the line alive.
    snapCounts();
    applyStimulus("T12:3", 1'b0);
    idle(TMO - 1);
    applyStimulus("4:56:78", 1'b1);
    checkOutput("tmo_race_valid", 32'(o_time_valid), 32'h1);
    checkOutput("tmo_race_data", 32'(o_time_data), 32'h645C4E);
    idle(3);
    checkOutput("tmo_race_err_count", 32'(errCnt - baseErr), 32'd0);

    // Reset mid-line: partial line lost, no error.
    snapCounts();
    applyStimulus("T12:34", 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checkOutput("midrst_outputs", {1'b0, o_time_data, o_time_valid, o_sw_run, o_sw_stop,
                                   o_sw_clear, o_err, o_busy}, 32'h0);
    idle(3);
    checkOutput("midrst_err_count", 32'(errCnt - baseErr), 32'd0);

    // 01:02:03:04 -> (1<<19)|(2<<13)|(3<<7)|4.
    applyStimulus("T01:02:03:04", 1'b1);
    checkOutput("post_rst_valid", 32'(o_time_valid), 32'h1);
    checkOutput("post_rst_data", 32'(o_time_data), 32'h084184);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
